// File: rtl/alu_exec_unit.sv
// alu_exec_unit - execute-stage ALU with an iterative shift-add multiplier.
//
// Single-cycle ops (and, xor, sll, add, sub, srai, address add, beq compare)
// resolve combinationally. MUL is retired MUL_BITS multiplier bits per cycle
// while stall_o freezes the front of the pipeline; the product is presented
// for one cycle in MUL_DONE.
//
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   valid_i    ID/EX holds a live instruction
//   ALUCtrl_i  4-bit operation code
//   data1_i    operand A (rs1)
//   data2_i    operand B (rs2 or immediate)
//   flush_i    kill in-flight instruction (branch taken)
//   result_o   ALU result, 0 when not valid
//   zero_o     result_o == 0 (branch resolution)
//   valid_o    result_o is valid this cycle
//   stall_o    hold PC/IF-ID/ID-EX and insert a bubble
//
// Optional build macro: MUL_EARLY_TERM_EN
//   When defined, a multiply finishes as soon as the remaining multiplier bits
//   are all zero (a zero multiplier completes straight from IDLE).
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | single-cycle ops pass through; a valid MUL loads the operands
// MUL_BUSY | one shift-add iteration per cycle, stall_o held high
// MUL_DONE | product on result_o with valid_o for one cycle

module alu_exec_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_BITS = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [3:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             valid_o,
    output logic             stall_o
);

    localparam int ITERS = WIDTH / MUL_BITS;
    localparam int CNT_W = $clog2(ITERS + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   count;

    logic               is_mul;
    logic               mul_start;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH-1:0]   partial;
    logic [WIDTH-1:0]   mplier_shr;
    logic [WIDTH-1:0]   res_int;
    logic               valid_int;
    logic               stall_int;

    assign is_mul     = (ALUCtrl_i == 4'b0101);
    assign mul_start  = (state == IDLE) && valid_i && is_mul && !flush_i;
    assign mplier_shr = mplier >> MUL_BITS;

    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            4'b0000: alu_res = data1_i & data2_i;
            4'b0001: alu_res = data1_i ^ data2_i;
            4'b0010: alu_res = data1_i << data2_i[4:0];
            4'b0011,
            4'b0110,
            4'b1000: alu_res = data1_i + data2_i;
            4'b0100,
            4'b1001: alu_res = data1_i - data2_i;
            4'b0111: alu_res = $signed(data1_i) >>> data2_i[4:0];
            default: alu_res = '0;
        endcase
    end

    // Shift-add partial product for the low MUL_BITS multiplier bits.
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        valid_int = 1'b0;
        stall_int = 1'b0;
        res_int   = '0;
        case (state)
            IDLE: begin
                if (valid_i && is_mul) begin
                    stall_int = 1'b1;
                end else if (valid_i) begin
                    valid_int = 1'b1;
                    res_int   = alu_res;
                end
                if (mul_start) begin
`ifdef MUL_EARLY_TERM_EN
                    state_nxt = (data2_i == '0) ? MUL_DONE : MUL_BUSY;
`else
                    state_nxt = MUL_BUSY;
`endif
                end
            end
            MUL_BUSY: begin
                stall_int = 1'b1;
                if (count == CNT_W'(1)) begin
                    state_nxt = MUL_DONE;
                end
`ifdef MUL_EARLY_TERM_EN
                else if (mplier_shr == '0) begin
                    state_nxt = MUL_DONE;
                end
`endif
            end
            MUL_DONE: begin
                valid_int = 1'b1;
                res_int   = acc;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A flush kills the result now but leaves stall_o to the current state.
        if (flush_i) begin
            valid_int = 1'b0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_start) begin
                        acc    <= '0;
                        mcand  <= data1_i;
                        mplier <= data2_i;
                        count  <= CNT_W'(ITERS);
                    end
                end
                MUL_BUSY: begin
                    acc    <= acc + partial;
                    mcand  <= mcand << MUL_BITS;
                    mplier <= mplier_shr;
                    count  <= count - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs read as zero while reset is held.
    assign valid_o  = valid_int && !rst_i;
    assign stall_o  = stall_int && !rst_i;
    assign result_o = valid_o ? res_int : '0;
    assign zero_o   = (result_o == '0);

endmodule
